jump_sequencer: RTL
===================

# jump_sequencer

Frame-tick-driven controller that sequences the player's vertical jump offset for the obstacle game. It turns a raw jump button into a rise/apex/fall/cooldown profile and drives a 10-bit height to the sprite renderer. It sits between the input synchronizer and the player-drawing logic, and advances only on the one-cycle-per-frame `tick` strobe.

## Interface
- `STEP`, 10: height change per tick in RISE/FALL; range 1..MAX_HEIGHT.
- `MAX_HEIGHT`, 100: apex height in pixels; must be ≤ 1023.
- `APEX_HOLD`, 2: ticks spent in APEX; must be ≥ 1.
- `COOLDOWN`, 4: ticks after landing before a new launch; 0 means land goes directly to IDLE.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset; the block is reset on a `clk` edge while `reset` = 0.
- `tick`  in  1  frame strobe, one `clk` cycle wide.
- `pause`  in  1  when 1, ticks are ignored and all state freezes; edge detection continues.
- `jump`  in  1  synchronized jump button (level).
- `height`  out  10  current vertical offset, registered.
- `airborne`  out  1  1 in RISE, APEX and FALL.
- `busy`  out  1  1 in any state other than IDLE.
- `land`  out  1  one-cycle pulse on the cycle after the landing tick.

## Operation
- States: IDLE, RISE, APEX, FALL, CDOWN. Internal signals: `pend` flag, `cnt`, and `jump_q` (the previous value of `jump`).
- A press edge is `jump & ~jump_q`, evaluated every cycle.
- `pend` is set by an edge in IDLE.
- A "live tick" is `tick & ~pause`. State, `height` and `cnt` change only on live ticks.
- IDLE, live tick with `pend` or with a same-cycle edge:
  - next state RISE, `height` ← STEP, `pend` ← 0.
  - Without a request, IDLE holds `height` at 0.
- RISE, live tick:
  - if `height` + STEP ≥ MAX_HEIGHT (11-bit compare): `height` ← MAX_HEIGHT, `cnt` ← 0, next state APEX.
  - otherwise `height` += STEP.
- APEX, live tick:
  - if `cnt` == APEX_HOLD−1: next state FALL, `height` unchanged.
  - otherwise `cnt` += 1.
- FALL, live tick:
  - if `height` ≤ STEP: `height` ← 0, `land` asserted next cycle, `cnt` ← 0, next state CDOWN (or IDLE when COOLDOWN = 0).
  - otherwise `height` −= STEP. There is no underflow.
- CDOWN, live tick:
  - if `cnt` == COOLDOWN−1: next state IDLE.
  - otherwise `cnt` += 1.
- Presses in RISE or APEX are discarded. Presses in FALL or CDOWN are governed by Configuration.
- `pause` mid-jump freezes `height` and the state. `land` cannot fire while paused.
- Reset mid-jump: the next cycle shows `height` = 0, IDLE, and `pend` = 0.

## Timing
- Reset values: `height` = 0, `airborne` = 0, `busy` = 0, `land` = 0, state IDLE, `pend` = 0, `cnt` = 0, `jump_q` = 1.
  - Because `jump_q` resets to 1, a button held through reset release does not launch; it must be released and pressed again.
- All outputs are registered.
  - `height`, `airborne` and `busy` reflect a live tick in the following cycle.
  - `land` is high for exactly one cycle.
- An edge coincident with a live tick in IDLE launches on that tick, so the latency is 1 cycle to `height` = STEP.
- An edge between ticks launches on the next live tick.
- Multiple edges before a launch collapse into a single request.
- With the defaults, a full jump takes 22 live ticks (10 rise, 2 apex, 10 fall) plus 4 cooldown ticks. The earliest relaunch is live tick 27.

## Configuration
- `JUMP_BUFFER_EN` defined:
  - an edge during FALL or CDOWN sets `pend`.
  - The buffered request launches on the first live tick in IDLE, so the jump chains without a second press.
- `JUMP_BUFFER_EN` undefined:
  - `pend` is set only in IDLE; edges in every other state are discarded.

## Test plan
- Defaults, one press, a live tick every 4 cycles:
  - `height` steps 10,20,…,100 on ticks 1–10.
  - `height` holds 100 on ticks 11–12.
  - `height` falls 90…0 on ticks 13–22.
  - `land` pulses once after tick 22; `busy` drops after tick 26.
- MAX_HEIGHT = 95, STEP = 10:
  - RISE clamps to 95 on tick 10.
  - FALL 85…5, then 0 on the landing tick; `height` never exceeds 95 and never wraps.
- Press during FALL at `height` = 40:
  - with `JUMP_BUFFER_EN`, `height` = 10 on tick 27 without a new press.
  - without it, `height` stays 0 until a new press.
- `pause` high for 20 cycles while `height` = 60 in RISE: `height` holds 60 through ticks issued during the pause, then resumes at 70.
- `jump` held high through reset release: no launch. After release and re-press, the launch occurs on the next live tick.
- `reset` = 0 asserted in APEX: one cycle later `height` = 0, `busy` = 0 and `land` = 0, and no stale `pend` remains.

Source files
------------

// File: rtl/jump_sequencer.sv
// ---------------------------------------------------------------------------
// jump_sequencer
//
// Purpose:
//   Frame-tick-driven controller for the player's vertical jump. A press edge
//   on the synchronized jump button launches a rise/apex/fall/cooldown height
//   profile. The profile advances only on live ticks (tick while not paused).
//
// Optional feature macro: JUMP_BUFFER_EN
//   When defined, a press edge during FALL or CDOWN is buffered. It then
//   launches the next jump on the first live tick back in IDLE.
//   When undefined, presses are only accepted in IDLE.
//
// Parameters:
//   STEP       height change per live tick in RISE/FALL (1..MAX_HEIGHT)
//   MAX_HEIGHT apex height in pixels (<= 1023)
//   APEX_HOLD  live ticks spent in APEX (>= 1)
//   COOLDOWN   live ticks after landing before IDLE (0 = straight to IDLE)
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-low reset
//   tick     in   one-cycle frame strobe
//   pause    in   freezes state while high (edge detection keeps running)
//   jump     in   synchronized jump button level
//   height   out  [9:0] current vertical offset (registered)
//   airborne out  high in RISE, APEX and FALL (registered)
//   busy     out  high in any state other than IDLE (registered)
//   land     out  one-cycle pulse on the cycle after the landing tick
// ---------------------------------------------------------------------------
module jump_sequencer #(
    parameter int STEP       = 10,
    parameter int MAX_HEIGHT = 100,
    parameter int APEX_HOLD  = 2,
    parameter int COOLDOWN   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       pause,
    input  logic       jump,
    output logic [9:0] height,
    output logic       airborne,
    output logic       busy,
    output logic       land
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RISE  = 3'd1,
        S_APEX  = 3'd2,
        S_FALL  = 3'd3,
        S_CDOWN = 3'd4
    } state_t;

    localparam logic [10:0] STEP_W11   = 11'(STEP);
    localparam logic [10:0] MAX_W11    = 11'(MAX_HEIGHT);
    localparam logic [9:0]  STEP_W10   = 10'(STEP);
    localparam logic [9:0]  MAX_W10    = 10'(MAX_HEIGHT);
    localparam logic [15:0] APEX_LAST  = 16'(APEX_HOLD - 1);
    // Only meaningful when COOLDOWN > 0; the guard keeps the cast non-negative.
    localparam logic [15:0] CDOWN_LAST = 16'((COOLDOWN > 0) ? (COOLDOWN - 1) : 0);

    state_t      r_state;
    logic [9:0]  r_height;
    logic [15:0] r_cnt;
    logic        r_pend;
    logic        r_jump_q;
    logic        r_airborne;
    logic        r_busy;
    logic        r_land;

    logic        w_press;
    logic        w_live;
    logic [10:0] w_rise_sum;
    logic        w_fall_done;

    // Press edge, live tick and the 11-bit rise/fall boundary tests.
    assign w_press     = jump & ~r_jump_q;
    assign w_live      = tick & ~pause;
    assign w_rise_sum  = {1'b0, r_height} + STEP_W11;
    assign w_fall_done = ({1'b0, r_height} <= STEP_W11);

    assign height   = r_height;
    assign airborne = r_airborne;
    assign busy     = r_busy;
    assign land     = r_land;

    // Jump FSM: state, height, counters, request flag and registered outputs.
    // airborne/busy are updated on the transitions that change them so they
    // always describe the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_height   <= 10'd0;
            r_cnt      <= 16'd0;
            r_pend     <= 1'b0;
            // Resetting to 1 means a button held through reset must be
            // released and pressed again before it can launch.
            r_jump_q   <= 1'b1;
            r_airborne <= 1'b0;
            r_busy     <= 1'b0;
            r_land     <= 1'b0;
        end else begin
            r_jump_q <= jump;
            r_land   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_live && (r_pend || w_press)) begin
                        r_state    <= S_RISE;
                        r_height   <= STEP_W10;
                        r_pend     <= 1'b0;
                        r_airborne <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (w_press) begin
                        r_pend <= 1'b1;
                    end else begin
                        r_height <= 10'd0;
                    end
                end
                S_RISE: begin
                    if (w_live) begin
                        if (w_rise_sum >= MAX_W11) begin
                            r_height <= MAX_W10;
                            r_cnt    <= 16'd0;
                            r_state  <= S_APEX;
                        end else begin
                            r_height <= w_rise_sum[9:0];
                        end
                    end else begin
                        r_height <= r_height;
                    end
                end
                S_APEX: begin
                    if (w_live) begin
                        if (r_cnt == APEX_LAST) begin
                            r_state <= S_FALL;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_FALL: begin
                    if (w_live) begin
                        if (w_fall_done) begin
                            r_height   <= 10'd0;
                            r_land     <= 1'b1;
                            r_cnt      <= 16'd0;
                            r_airborne <= 1'b0;
                            if (COOLDOWN == 0) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_CDOWN;
                            end
                        end else begin
                            r_height <= r_height - STEP_W10;
                        end
                    end else begin
                        r_height <= r_height;
                    end
`ifdef JUMP_BUFFER_EN
                    if (w_press) begin
                        r_pend <= 1'b1;
                    end else begin
                        r_pend <= r_pend;
                    end
`endif
                end
                S_CDOWN: begin
                    if (w_live) begin
                        if (r_cnt == CDOWN_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
`ifdef JUMP_BUFFER_EN
                    if (w_press) begin
                        r_pend <= 1'b1;
                    end else begin
                        r_pend <= r_pend;
                    end
`endif
                end
                default: begin
                    // Unreachable encoding: fall back to a clean IDLE.
                    r_state    <= S_IDLE;
                    r_height   <= 10'd0;
                    r_cnt      <= 16'd0;
                    r_pend     <= 1'b0;
                    r_airborne <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
